// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: state encoding and header decoding.
package boot_loader_ctrl_pkg;

    localparam int LDR_STATE_W = 3;

    // A header byte of zero requests a full 256-word image.
    localparam logic [8:0] LDR_ZERO_HDR_WORDS = 9'd256;

    typedef enum logic [LDR_STATE_W-1:0] {
        LDR_IDLE  = 3'd0,
        LDR_HDR   = 3'd1,
        LDR_HI    = 3'd2,
        LDR_LO    = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_CHK   = 3'd5,
        LDR_RUN   = 3'd6,
        LDR_ERR   = 3'd7
    } ldr_state_t;

    // Convert the header byte into the number of words still to load.
    function automatic logic [8:0] hdr_to_count(input logic [7:0] hdr);
        return (hdr == 8'h00) ? LDR_ZERO_HDR_WORDS : {1'b0, hdr};
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_checksum.sv
// loader_checksum: 8-bit modulo-256 running sum of the accepted stream bytes.
module loader_checksum (
    input  logic       CLK,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic [7:0] sum
);

    // Clear wins over accumulate so a new load always starts from zero.
    always_ff @(posedge CLK) begin
        if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum + byte_in;
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a program image from a byte stream into the 256x16
// RAM while holding the CPU in reset, verifies the checksum, then returns the
// RAM port to the CPU and releases CPU_NCLR after RST_HOLD cycles.
//
// Stream handshake: a byte transfers on a rising CLK edge where IN_VALID and
// IN_READY are both 1. IN_READY is a registered function of state only (1 in
// HDR, HI, LO, CHK) and never looks at IN_VALID; the source may raise or drop
// IN_VALID freely and must hold IN_DATA while IN_VALID is high and not taken.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned RST_HOLD  = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    output logic        RAM_WE,
    output logic [7:0]  RAM_ADDR,
    output logic [15:0] RAM_DIN,
    output logic        LOADER_OWN,
    output logic        CPU_NCLR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    // CPU side of the RAM port and the muxed port that drives the RAM
    input  logic        CPU_WE,
    input  logic [7:0]  CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    output logic        MEM_WE,
    output logic [7:0]  MEM_ADDR,
    output logic [15:0] MEM_DIN,
    // Current controller state, for observation only
    output logic [LDR_STATE_W-1:0] STATE
);

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    ldr_state_t state;
    logic [8:0] count;
    logic [3:0] hold_cnt;
    logic [7:0] cks_sum;
    logic       xfer;
    logic       start_take;
    logic       cks_clr;
    logic       cks_en;

    assign xfer       = IN_VALID & IN_READY;
    assign start_take = START & ((state == LDR_IDLE) | (state == LDR_RUN) | (state == LDR_ERR));
    assign cks_clr    = CLR | start_take;
    // The checksum byte itself is never folded into the sum.
    assign cks_en     = xfer & ((state == LDR_HDR) | (state == LDR_HI) | (state == LDR_LO));

    loader_checksum u_checksum (
        .CLK     (CLK),
        .clr     (cks_clr),
        .en      (cks_en),
        .byte_in (IN_DATA),
        .sum     (cks_sum)
    );

    // Load sequencer: state plus every registered output, reset by CLR.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= LDR_IDLE;
            IN_READY   <= 1'b0;
            RAM_WE     <= 1'b0;
            RAM_ADDR   <= BASE_ADDR;
            RAM_DIN    <= 16'h0000;
            LOADER_OWN <= 1'b1;
            CPU_NCLR   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            count      <= 9'd0;
            hold_cnt   <= 4'd0;
        end else if (start_take) begin
            // START reclaims the RAM port and re-holds the CPU on the same edge.
            state      <= LDR_HDR;
            IN_READY   <= 1'b1;
            RAM_WE     <= 1'b0;
            RAM_ADDR   <= BASE_ADDR;
            LOADER_OWN <= 1'b1;
            CPU_NCLR   <= 1'b0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            hold_cnt   <= 4'd0;
        end else begin
            RAM_WE <= 1'b0;
            case (state)
                LDR_HDR: begin
                    if (xfer) begin
                        count <= hdr_to_count(IN_DATA);
                        state <= LDR_HI;
                    end
                end
                LDR_HI: begin
                    if (xfer) begin
                        RAM_DIN[15:8] <= IN_DATA;
                        state         <= LDR_LO;
                    end
                end
                LDR_LO: begin
                    if (xfer) begin
                        RAM_DIN[7:0] <= IN_DATA;
                        RAM_WE       <= 1'b1;
                        IN_READY     <= 1'b0;
                        state        <= LDR_WRITE;
                    end
                end
                LDR_WRITE: begin
                    // The write happens this cycle; advance for the next word.
                    RAM_ADDR <= RAM_ADDR + 8'd1;
                    count    <= count - 9'd1;
                    IN_READY <= 1'b1;
                    state    <= (count == 9'd1) ? LDR_CHK : LDR_HI;
                end
                LDR_CHK: begin
                    if (xfer) begin
                        IN_READY <= 1'b0;
                        BUSY     <= 1'b0;
                        if (IN_DATA == cks_sum) begin
                            state      <= LDR_RUN;
                            LOADER_OWN <= 1'b0;
                            DONE       <= 1'b1;
                            hold_cnt   <= 4'd0;
                        end else begin
                            state <= LDR_ERR;
                            ERROR <= 1'b1;
                        end
                    end
                end
                LDR_RUN: begin
                    // CPU reset is released RST_HOLD edges after the port handover.
                    if (!CPU_NCLR) begin
                        if (hold_cnt == HOLD_LAST) begin
                            CPU_NCLR <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    // IDLE and ERR only leave on START, handled above.
                    state <= state;
                end
            endcase
        end
    end

    // RAM port mux: loader drives the RAM while it owns the port.
    always_comb begin
        MEM_WE   = LOADER_OWN ? RAM_WE   : CPU_WE;
        MEM_ADDR = LOADER_OWN ? RAM_ADDR : CPU_ADDR;
        MEM_DIN  = LOADER_OWN ? RAM_DIN  : CPU_DIN;
    end

    assign STATE = state;

endmodule
